// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO result registers
// Shift-add multiply and restoring divide on operand magnitudes; sign fix-up in a final cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_SIGN,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [1:0]         op_q;
   logic               sign_a_q;
   logic               sign_b_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   hi_d;
   logic [WIDTH-1:0]   lo_d;
   logic               busy_q;
   logic               done_q;
   logic               dbz_q;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_diff;
   logic [2*WIDTH-1:0] prod_neg;
   logic               neg_res;

   always_comb begin
      mag_a    = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
      mag_b    = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;
      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, mcand_q};
      // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, quotient}.
      if (!op_q[1]) begin
         acc_d = {add_sum, acc_q[WIDTH-1:1]};
      end else if (!rem_diff[WIDTH]) begin
         acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end

      neg_res  = sign_a_q ^ sign_b_q;
      prod_neg = -acc_q;
      hi_d     = acc_q[2*WIDTH-1:WIDTH];
      lo_d     = acc_q[WIDTH-1:0];
      if (op_q == 2'b01 && neg_res) begin
         {hi_d, lo_d} = prod_neg;
      end else if (op_q == 2'b11) begin
         if (neg_res) lo_d = -acc_q[WIDTH-1:0];
         if (sign_a_q) hi_d = -acc_q[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q     <= op;
                  sign_a_q <= op[0] & operand_a[WIDTH-1];
                  sign_b_q <= op[0] & operand_b[WIDTH-1];
                  mcand_q  <= op[1] ? mag_b : mag_a;
                  acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                  cnt_q    <= '0;
                  if (op[1] && operand_b == '0) begin
                     hi_q    <= operand_a;
                     lo_q    <= '1;
                     dbz_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) state_q <= S_SIGN;
            end
            S_SIGN: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               dbz_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against a transaction-level model
module tb_mult_div_unit;
   logic        clock = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: m_cnt counts edges until the op is retired (34 = just accepted, 1 = done cycle, 0 = idle).
   int          m_cnt = 0;
   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;
   logic        m_dbz = 1'b0;
   logic [31:0] p_hi  = '0;
   logic [31:0] p_lo  = '0;
   logic [64:0] ref_now;

   always #5 clock = ~clock;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   function automatic logic [64:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx;
      longint      sy;
      longint      q;
      longint      r;
      logic [63:0] p;
      sx = $signed(x);
      sy = $signed(y);
      case (o)
         2'd0: begin
            p = {32'b0, x} * {32'b0, y};
            return {1'b0, p};
         end
         2'd1: begin
            q = sx * sy;
            return {1'b0, q[63:0]};
         end
         2'd2: begin
            if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
            return {1'b0, x % y, x / y};
         end
         default: begin
            if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
            q = sx / sy;
            r = sx % sy;
            return {1'b0, r[31:0], q[31:0]};
         end
      endcase
   endfunction

   always_comb ref_now = ref_calc(op, operand_a, operand_b);

   always @(posedge clock or posedge rst) begin
      if (rst) begin
         m_cnt <= 0;
         m_hi  <= '0;
         m_lo  <= '0;
         m_dbz <= 1'b0;
      end else if (m_cnt == 0) begin
         if (start) begin
            if (ref_now[64]) begin
               m_cnt <= 1;
               m_hi  <= ref_now[63:32];
               m_lo  <= ref_now[31:0];
               m_dbz <= 1'b1;
            end else begin
               m_cnt <= 34;
               p_hi  <= ref_now[63:32];
               p_lo  <= ref_now[31:0];
            end
         end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) begin
            m_hi  <= p_hi;
            m_lo  <= p_lo;
            m_dbz <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("busy", 32'(busy), 32'(m_cnt >= 2));
      chk("done", 32'(done), 32'(m_cnt == 1));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // lat = edges from the accepting edge until done is first seen.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit glitch, output int lat);
      @(negedge clock);
      op = o; operand_a = x; operand_b = y; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      op = 2'($urandom_range(0, 3)); operand_a = $urandom; operand_b = $urandom;
      lat = 0;
      while (!done && lat < 80) begin
         if (glitch && lat == 9) begin
            start = 1'b1;
            op = 2'($urandom_range(0, 3)); operand_a = $urandom; operand_b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         lat++;
      end
      start = 1'b0;
      if (lat >= 80) chk("done_timeout", 32'(lat), 32'd33);
   endtask

   typedef struct packed {
      logic [1:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] eh;
      logic [31:0] el;
      logic        ed;
      logic [7:0]  lat;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ndone;
      rst = 1'b1; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
      repeat (3) @(negedge clock);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      rst = 1'b0;

      vecs[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 8'd33};
      vecs[1] = '{2'd1, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 8'd33};
      vecs[2] = '{2'd0, 32'hFFFFFFFD, 32'h7,        32'h00000006, 32'hFFFFFFEB, 1'b0, 8'd33};
      vecs[3] = '{2'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 8'd33};
      vecs[4] = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 8'd33};
      vecs[5] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 8'd33};
      vecs[6] = '{2'd3, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 8'd0};
      vecs[7] = '{2'd0, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 8'd33};
      vecs[8] = '{2'd0, 32'd1000,     32'd1000,     32'd0,        32'h000F4240, 1'b0, 8'd33};

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].o, vecs[i].x, vecs[i].y, i == 8, lat);
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].eh);
         chk($sformatf("vec%0d_lo", i), lo, vecs[i].el);
         chk($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].ed));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      for (int i = 0; i < 40; i++) begin
         do_op(2'($urandom_range(0, 3)), pick(), pick(), bit'($urandom_range(0, 1)), lat);
      end

      @(negedge clock);
      op = 2'd0; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
      ndone = 0;
      for (int n = 0; n < 150 && ndone < 2; n++) begin
         @(negedge clock);
         if (done) begin
            ndone++;
            chk("held_lo", lo, 32'd42);
         end
      end
      start = 1'b0;
      chk("held_two_done", 32'(ndone), 32'd2);

      @(negedge clock);
      op = 2'd2; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (14) @(negedge clock);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_dbz", 32'(div_by_zero), 32'd0);
      chk("async_rst_hi", hi, 32'd0);
      chk("async_rst_lo", lo, 32'd0);
      @(negedge clock);
      @(negedge clock);
      rst = 1'b0;
      do_op(2'd0, 32'd5, 32'd5, 1'b0, lat);
      chk("post_rst_lo", lo, 32'd25);
      chk("post_rst_hi", hi, 32'd0);
      chk("post_rst_latency", 32'(lat), 32'd33);

      repeat (3) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit. It sits directly downstream of the register file and consumes its two read ports (readOut_1 → operand_a, readOut_2 → operand_b).
- Produces a 64-bit product or a quotient/remainder pair into internal HI/LO result registers, which the datapath reads back later.
- Runs one radix-2 step per clock; the pipeline control stalls on busy.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH split into hi/lo. Only 32 is verified.

Ports:
- clock  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request. Sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- operand_a  input  WIDTH  multiplicand / dividend (from readOut_1).
- operand_b  input  WIDTH  multiplier / divisor (from readOut_2).
- busy  output  1  high while an operation is in progress (CALC, SIGN).
- done  output  1  one-cycle pulse when hi/lo hold a new result.
- div_by_zero  output  1  registered flag, valid with done.
- hi  output  WIDTH  product[63:32] or remainder.
- lo  output  WIDTH  product[31:0] or quotient.

Behaviour:
- Clock and reset: one clock (clock). Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, step counter=0, internal operand/accumulator registers=0.
- States are IDLE, CALC, SIGN, DONE. busy=1 only in CALC and SIGN. done=1 only in DONE.
- IDLE → CALC:
  - Occurs on a rising edge with start=1.
  - That edge latches op, the operand magnitudes, and the result sign bits. For signed ops the magnitude is the two's-complement absolute value; 0x80000000 has magnitude 0x80000000 treated as unsigned.
  - Operand changes after the accepting edge are ignored.
- Divide by zero: on the accepting edge, if op is 10/11 and operand_b=0, go IDLE → DONE directly.
  - hi=operand_a, lo=32'hFFFFFFFF, div_by_zero=1.
  - done rises one cycle after accept.
- CALC:
  - Exactly 32 cycles, with a 5-bit counter running 0..31. Transition to SIGN on the edge where counter=31.
  - Multiply: shift-add. If the accumulator LSB is 1, add the multiplicand to the upper half, then shift the 65-bit {carry, acc} right by 1.
  - Divide: restoring. Shift {rem, quo} left 1. If rem ≥ divisor, subtract and set quo LSB=1. Comparison is 33-bit unsigned.
- SIGN (1 cycle):
  - Signed multiply: negate the 64-bit product if sign_a XOR sign_b.
  - Signed divide: negate the quotient if sign_a XOR sign_b, and negate the remainder if sign_a.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Unsigned ops pass through unchanged.
  - Results are written to hi/lo on the SIGN→DONE edge, and div_by_zero is cleared there.
- Latency: accept on edge 0, SIGN after edge 32, DONE after edge 33 (hi/lo valid, done=1), IDLE after edge 34. The next start can be accepted on edge 34.
- DONE → IDLE is unconditional. start asserted in DONE is ignored; the requester must hold or re-assert start in IDLE.
- start while busy or done is ignored, with no queueing.
- hi/lo hold the last result until the next DONE entry. They are not cleared by a new start.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, div_by_zero=0.
- rst asserted mid-operation: immediate return to the reset values, and the in-flight result is discarded. rst takes precedence over start on the same edge.
- No X propagation: all registers are reset; the op decode covers all four codes.

Test Plan:
- Unsigned multiply: MULTU 0xFFFFFFFF × 0xFFFFFFFF, start on edge 0 → busy=1 edges 1–33, done=1 after edge 33 only, hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- Signed multiply: MULT 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU on the same operands → hi=0x00000006, lo=0xFFFFFFEB.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 → lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIV 0x12345678 / 0 → done one cycle after accept, hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1. A following MULTU 2×3 → div_by_zero=0, hi=0, lo=6.
- Handshake:
  - Assert start again on edge 10 of a running op with different operands → ignored, original result unchanged.
  - Change operand_a mid-CALC → no effect on the result.
  - Start held through DONE → second operation accepted on edge 34, done again after edge 67.
- Reset mid-operation: assert rst asynchronously (between edges) at cycle 15 of DIVU → busy, done, hi, lo, div_by_zero all 0 immediately. After release, a new MULTU 5×5 completes normally with lo=25.
